vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA controller: consumes the on-board VGA signal set (HSYNC, VSYNC, BLANK, 10-bit RGB) and recovers pixel coordinates, line/frame timing and a lock indication.
- Used on-chip as a loopback monitor to verify the pixel generator and timing unit, and as a front end for later frame-capture blocks.

Parameters:
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive consistent frames required to assert lock (1..15)

Ports:
- Clock  input  1  pixel clock, same 25 MHz domain as the VGA controller
- Reset  input  1  synchronous, active-high
- iVGA_H_SYNC  input  1  horizontal sync, active-low
- iVGA_V_SYNC  input  1  vertical sync, active-low
- iVGA_BLANK  input  1  blank, active-low (1 = active video)
- iVGA_R / iVGA_G / iVGA_B  input  10 each  pixel colour
- oPixel_valid  output  1  active pixel on oCoord/oRGB this cycle
- oCoord_X  output  10  recovered column
- oCoord_Y  output  10  recovered row
- oRed / oGreen / oBlue  output  10 each  pixel colour aligned with oPixel_valid
- oLine_period  output  12  clocks between last two HSYNC falling edges
- oLines_per_frame  output  11  HSYNC falling edges in last complete frame
- oLocked  output  1  timing stable and matches H_ACTIVE x V_ACTIVE
- oError  output  1  sticky: lock lost after having been acquired
- oFrame_crc  output  16  see Optional Feature

Behaviour:
- One clock domain. All inputs registered once on entry (stage 1); all outputs registered (stage 2). Pixel presented at cycle n appears on oPixel_valid/oCoord/oRGB at n+2.
- Reset (any cycle, including mid-frame): all outputs 0, all counters 0, FSM to SEARCH, oError cleared.
- Edges are detected on stage-1 samples vs. previous sample. HSYNC/VSYNC falling edge = prev 1, now 0.
- Horizontal counter: +1 per clock, saturates at 4095. On an HSYNC falling edge: oLine_period <= counter + 1, then counter restarts at 0. Standard 800-clock line gives 800. A saturated value is a timing mismatch.
- Line counter: +1 per HSYNC falling edge, saturates at 2047. On a VSYNC falling edge: oLines_per_frame <= count, then restarts. An HSYNC edge coincident with the VSYNC edge counts as line 1 of the new frame.
- X: 0 on first BLANK-high cycle of a run, +1 per active cycle, saturates at 1023.
- Y: 0 at VSYNC falling edge. +1 at the end (BLANK falling edge) of each active run.
- oPixel_valid = registered BLANK high.
- Per line: active run length is compared with H_ACTIVE. Per frame: active-line count is compared with V_ACTIVE, and oLine_period must be constant across the frame. Any failure marks the frame bad.
- FSM states SEARCH, TRACK, LOCKED, evaluated at each VSYNC falling edge:
  - SEARCH -> TRACK on first VSYNC falling edge; good-frame count cleared.
  - TRACK: good frame increments the count; bad frame clears it. Count = LOCK_FRAMES -> LOCKED.
  - LOCKED: bad frame -> SEARCH and oError set.
  - oLocked = 1 only in LOCKED.
- Frames whose start precedes lock acquisition are never bad by partial observation: the first partial frame after reset is discarded (the SEARCH exit).

Optional Feature:
- Macro VGA_DECODER_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over {R[9:8],G[9:8],B[9:8]} of every valid pixel in raster order, 6 bits per pixel, MSB first. Value latched to oFrame_crc at each VSYNC falling edge; accumulator then re-initialised.
- Undefined: oFrame_crc tied to 0 and no CRC logic synthesised.

Test Plan:
- Standard 640x480 stream (800 clk lines, 525 lines, HSYNC low 96 clk) from reset -> oLine_period=800, oLines_per_frame=525 after 2nd VSYNC edge; oLocked=1 at the VSYNC edge ending the 3rd frame with LOCK_FRAMES=2.
- Locked, pixel at row 479 col 639 with R=G=B=0x3FF -> two cycles later oPixel_valid=1, oCoord_X=639, oCoord_Y=479, oRed=0x3FF.
- Locked, one frame with a 801-clock line -> oLocked=0 and oError=1 at that frame's closing VSYNC edge. oError remains 1 through relock until Reset.
- Reset asserted mid-line while locked -> next cycle all outputs 0, FSM SEARCH; relock takes LOCK_FRAMES+1 frames.
- Stream with 639 active pixels per line -> oLocked never asserts; oLine_period still 800.
- VGA_DECODER_CRC_EN defined, two identical frames -> identical nonzero oFrame_crc. One pixel changed in 3rd frame -> different value. Undefined -> oFrame_crc=0 always.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers pixel coordinates, line/frame timing and lock from HSYNC/VSYNC/BLANK/RGB.
// Optional frame CRC-16-CCITT over the pixel MSBs is built when VGA_DECODER_CRC_EN is defined.
`timescale 1ns/1ps

module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iVGA_H_SYNC,
  input  logic        iVGA_V_SYNC,
  input  logic        iVGA_BLANK,
  input  logic [9:0]  iVGA_R,
  input  logic [9:0]  iVGA_G,
  input  logic [9:0]  iVGA_B,
  output logic        oPixel_valid,
  output logic [9:0]  oCoord_X,
  output logic [9:0]  oCoord_Y,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic [11:0] oLine_period,
  output logic [10:0] oLines_per_frame,
  output logic        oLocked,
  output logic        oError,
  output logic [15:0] oFrame_crc
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [11:0] H_MAX  = 12'hFFF;
  localparam logic [10:0] L_MAX  = 11'h7FF;
  localparam logic [9:0]  XY_MAX = 10'h3FF;
  localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_GOOD = 10'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  // Stage 1: input samples and their previous values for edge detection
  logic       hs_q, vs_q, blank_q;
  logic       hs_prev_q, vs_prev_q, blank_prev_q;
  logic [9:0] r_q, g_q, b_q;

  // Timing trackers
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        line_seen_q, line_seen_d;
  logic        frame_bad_q, frame_bad_d;
  state_e      state_q, state_d;
  logic [3:0]  good_q, good_d;

  // Stage 2: registered outputs
  logic        valid_q;
  logic [9:0]  red_q, green_q, blue_q;
  logic [11:0] period_q, period_d;
  logic [10:0] lines_q, lines_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;

  logic        hs_fall, vs_fall, blank_rise, blank_fall;
  logic [11:0] period_meas;
  logic [9:0]  y_inc;
  logic [9:0]  active_lines;
  logic        line_bad, frame_bad_now, frame_good;

  assign hs_fall    = hs_prev_q & ~hs_q;
  assign vs_fall    = vs_prev_q & ~vs_q;
  assign blank_rise = blank_q & ~blank_prev_q;
  assign blank_fall = blank_prev_q & ~blank_q;

  assign period_meas  = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 12'd1;
  assign y_inc        = (y_q == XY_MAX) ? XY_MAX : y_q + 10'd1;
  assign active_lines = blank_fall ? y_inc : y_q;

  // A line is bad on a saturated or changed period, or a wrong active run length.
  assign line_bad = (hs_fall && ((period_meas == H_MAX) ||
                                 (line_seen_q && (period_meas != period_q)))) ||
                    (blank_fall && (x_q != X_LAST));
  assign frame_bad_now = frame_bad_q | line_bad;
  assign frame_good    = ~frame_bad_now && (active_lines == Y_GOOD);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    h_cnt_d     = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 12'd1;
    period_d    = period_q;
    line_cnt_d  = line_cnt_q;
    lines_d     = lines_q;
    x_d         = x_q;
    y_d         = y_q;
    line_seen_d = line_seen_q;
    frame_bad_d = frame_bad_now;

    if (hs_fall) begin
      h_cnt_d     = 12'd0;
      period_d    = period_meas;
      line_cnt_d  = (line_cnt_q == L_MAX) ? L_MAX : line_cnt_q + 11'd1;
      line_seen_d = 1'b1;
    end

    if (blank_q) begin
      x_d = blank_rise ? 10'd0 : ((x_q == XY_MAX) ? XY_MAX : x_q + 10'd1);
    end

    if (blank_fall) begin
      y_d = y_inc;
    end

    // A coincident HSYNC edge becomes line 1 of the new frame.
    if (vs_fall) begin
      lines_d     = line_cnt_q;
      line_cnt_d  = hs_fall ? 11'd1 : 11'd0;
      y_d         = 10'd0;
      line_seen_d = 1'b0;
      frame_bad_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    error_d = error_q;

    if (vs_fall) begin
      unique case (state_q)
        SEARCH: begin
          state_d = TRACK;
          good_d  = 4'd0;
        end
        TRACK: begin
          if (frame_good) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = 4'd0;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            state_d = SEARCH;
            error_d = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = 4'd0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      blank_q      <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      blank_prev_q <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      h_cnt_q      <= '0;
      line_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      line_seen_q  <= 1'b0;
      frame_bad_q  <= 1'b0;
      state_q      <= SEARCH;
      good_q       <= '0;
      valid_q      <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      period_q     <= '0;
      lines_q      <= '0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      hs_q         <= iVGA_H_SYNC;
      vs_q         <= iVGA_V_SYNC;
      blank_q      <= iVGA_BLANK;
      hs_prev_q    <= hs_q;
      vs_prev_q    <= vs_q;
      blank_prev_q <= blank_q;
      r_q          <= iVGA_R;
      g_q          <= iVGA_G;
      b_q          <= iVGA_B;
      h_cnt_q      <= h_cnt_d;
      line_cnt_q   <= line_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_seen_q  <= line_seen_d;
      frame_bad_q  <= frame_bad_d;
      state_q      <= state_d;
      good_q       <= good_d;
      valid_q      <= blank_q;
      red_q        <= r_q;
      green_q      <= g_q;
      blue_q       <= b_q;
      period_q     <= period_d;
      lines_q      <= lines_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
    end
  end

  assign oPixel_valid     = valid_q;
  assign oCoord_X         = x_q;
  assign oCoord_Y         = y_q;
  assign oRed             = red_q;
  assign oGreen           = green_q;
  assign oBlue            = blue_q;
  assign oLine_period     = period_q;
  assign oLines_per_frame = lines_q;
  assign oLocked          = locked_q;
  assign oError           = error_q;

`ifdef VGA_DECODER_CRC_EN
  // CRC-16-CCITT, six bits per valid pixel, MSB first.
  function automatic logic [15:0] crc6_step(input logic [15:0] crc_in, input logic [5:0] bits);
    logic [15:0] c;
    c = crc_in;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  logic [15:0] crc_acc_q, crc_acc_d, crc_base;
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_base  = vs_fall ? 16'hFFFF : crc_acc_q;
    crc_acc_d = blank_q ? crc6_step(crc_base, {r_q[9:8], g_q[9:8], b_q[9:8]}) : crc_base;
    crc_d     = vs_fall ? crc_acc_q : crc_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      crc_acc_q <= 16'hFFFF;
      crc_q     <= '0;
    end else begin
      crc_acc_q <= crc_acc_d;
      crc_q     <= crc_d;
    end
  end

  assign oFrame_crc = crc_q;
`else
  assign oFrame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 16x6 raster (24-clock lines, 10-line frames).
`timescale 1ns/1ps

module tb_vga_sync_decoder;

  localparam int HA   = 16;
  localparam int VA   = 6;
  localparam int HT   = 24;
  localparam int VT   = 10;
  localparam int HS_B = 18;
  localparam int HS_E = 22;
  localparam int VS_B = 7;
  localparam int VS_E = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs, blank;
  logic [9:0]  r, g, b;
  logic        o_valid;
  logic [9:0]  o_x, o_y, o_r, o_g, o_b;
  logic [11:0] o_period;
  logic [10:0] o_lines;
  logic        o_locked, o_error;
  logic [15:0] o_crc;

  int          checks   = 0;
  int          failures = 0;
  int          probe_cd = 0;
  int          exp_x, exp_y;
  bit          saw_lock;
  logic        prev_vs;
  logic [15:0] m_acc, m_last, crc_f2, crc_f3;

  always #20 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .LOCK_FRAMES(2)
  ) dut (
    .Clock           (clk),
    .Reset           (rst),
    .iVGA_H_SYNC     (hs),
    .iVGA_V_SYNC     (vs),
    .iVGA_BLANK      (blank),
    .iVGA_R          (r),
    .iVGA_G          (g),
    .iVGA_B          (b),
    .oPixel_valid    (o_valid),
    .oCoord_X        (o_x),
    .oCoord_Y        (o_y),
    .oRed            (o_r),
    .oGreen          (o_g),
    .oBlue           (o_b),
    .oLine_period    (o_period),
    .oLines_per_frame(o_lines),
    .oLocked         (o_locked),
    .oError          (o_error),
    .oFrame_crc      (o_crc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc6(input logic [15:0] crc_in, input logic [5:0] bits);
    logic [15:0] c;
    c = crc_in;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // One pixel clock of raster stimulus; also runs the pending pixel probe and the CRC model.
  task automatic drive_cycle(input int line, input int h, input int act_len, input bit probe);
    logic [9:0] rr, gg, bb;
    @(negedge clk);
    if (o_locked) saw_lock = 1'b1;
    if (probe_cd > 0) begin
      probe_cd--;
      if (probe_cd == 0) begin
        check("pix_valid", o_valid, 1);
        check("pix_x", o_x, exp_x);
        check("pix_y", o_y, exp_y);
        check("pix_r", o_r, 10'h3FF);
        check("pix_g", o_g, 10'h3FF);
        check("pix_b", o_b, 10'h3FF);
      end
    end
    rr = 10'((h * 67 + line * 131) % 1024);
    gg = 10'((h * 29 + line * 250) % 1024);
    bb = 10'((h * 512 + line * 300) % 1024);
    if (probe) begin
      rr = 10'h3FF;
      gg = 10'h3FF;
      bb = 10'h3FF;
    end
    blank = (line < VA) && (h < act_len);
    hs    = !(h >= HS_B && h < HS_E);
    vs    = !(line >= VS_B && line < VS_E);
    r     = rr;
    g     = gg;
    b     = bb;
    if (prev_vs && !vs) begin
      m_last = m_acc;
      m_acc  = 16'hFFFF;
    end
    if (blank) m_acc = crc6(m_acc, {rr[9:8], gg[9:8], bb[9:8]});
    prev_vs = vs;
    if (probe) begin
      exp_x    = h;
      exp_y    = line;
      probe_cd = 2;
    end
  endtask

  task automatic drive_frame(input int long_line, input int act_len, input int probe_line, input int probe_h);
    for (int line = 0; line < VT; line++) begin
      for (int h = 0; h < HT + ((line == long_line) ? 1 : 0); h++) begin
        drive_cycle(line, h, act_len, (line == probe_line) && (h == probe_h));
      end
    end
  endtask

  // Holds inputs through one reset clock, checks every output cleared, then idles the bus.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_rgb"}, {o_r, o_g, o_b}, 0);
    check({tag, "_period"}, o_period, 0);
    check({tag, "_lines"}, o_lines, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_error"}, o_error, 0);
    check({tag, "_crc"}, o_crc, 0);
    rst      = 1'b0;
    hs       = 1'b1;
    vs       = 1'b1;
    blank    = 1'b0;
    prev_vs  = 1'b0;
    m_acc    = 16'hFFFF;
    m_last   = 16'h0000;
    probe_cd = 0;
    saw_lock = 1'b0;
  endtask

  task automatic crc_check(input string tag);
`ifdef VGA_DECODER_CRC_EN
    check(tag, o_crc, m_last);
    check({tag, "_nonzero"}, o_crc != 16'h0000, 1);
`else
    check(tag, o_crc, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst   = 1'b0;
    hs    = 1'b1;
    vs    = 1'b1;
    blank = 1'b0;
    r     = '0;
    g     = '0;
    b     = '0;
    prev_vs = 1'b0;
    m_acc   = 16'hFFFF;
    m_last  = 16'h0000;

    do_reset("rst0");

    // Acquisition from reset: first partial frame discarded, lock after the third VSYNC edge.
    drive_frame(-1, HA, -1, -1);
    check("f1_lines", o_lines, 7);
    check("f1_locked", o_locked, 0);
    drive_frame(-1, HA, -1, -1);
    check("f2_period", o_period, 24);
    check("f2_lines", o_lines, 10);
    check("f2_locked", o_locked, 0);
    crc_check("f2_crc");
    crc_f2 = m_last;
    drive_frame(-1, HA, -1, -1);
    check("f3_locked", o_locked, 1);
    check("f3_error", o_error, 0);
    crc_check("f3_crc");
`ifdef VGA_DECODER_CRC_EN
    check("f3_crc_same", o_crc, crc_f2);
`endif
    crc_f3 = m_last;

    // Last active pixel forced to full scale while locked.
    drive_frame(-1, HA, VA - 1, HA - 1);
    check("f4_locked", o_locked, 1);
    crc_check("f4_crc");
`ifdef VGA_DECODER_CRC_EN
    check("f4_crc_differs", o_crc != crc_f3, 1);
`endif

    // One 25-clock line breaks lock and sets the sticky error.
    drive_frame(2, HA, -1, -1);
    check("f5_locked", o_locked, 0);
    check("f5_error", o_error, 1);
    check("f5_period", o_period, 24);
    check("f5_lines", o_lines, 10);
    drive_frame(-1, HA, -1, -1);
    check("f6_locked", o_locked, 0);
    drive_frame(-1, HA, -1, -1);
    check("f7_locked", o_locked, 0);
    drive_frame(-1, HA, -1, -1);
    check("f8_locked", o_locked, 1);
    check("f8_error", o_error, 1);

    // Reset in the middle of an active line while locked.
    for (int line = 0; line < 3; line++) begin
      for (int h = 0; h < ((line == 2) ? 8 : HT); h++) begin
        drive_cycle(line, h, HA, 1'b0);
      end
    end
    do_reset("rst_mid");
    drive_frame(-1, HA, -1, -1);
    check("r1_locked", o_locked, 0);
    drive_frame(-1, HA, -1, -1);
    check("r2_locked", o_locked, 0);
    drive_frame(-1, HA, -1, -1);
    check("r3_locked", o_locked, 1);
    check("r3_error", o_error, 0);

    // Lines one pixel short never lock.
    do_reset("rst_short");
    for (int f = 0; f < 5; f++) drive_frame(-1, HA - 1, -1, -1);
    check("short_never_locked", saw_lock, 0);
    check("short_period", o_period, 24);
    check("short_lines", o_lines, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
